// File: rtl/mrd_arbiter.sv
// Shares the bus read master between the IC and DC refill requesters.
// Define MRD_RR_ARB_EN for round-robin arbitration; default is DC priority.
module mrd_arbiter #(
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_pipe,
    input  logic              icr_start_rq,
    input  logic [AWIDTH-1:0] ic_rin_addr,
    output logic              ic_rdat_m_valid,
    output logic              ic_finish_mrd,
    input  logic              dcr_start_rq,
    input  logic [AWIDTH-1:0] dc_rin_addr,
    output logic              dc_rdat_m_valid,
    output logic              dc_finish_mrd,
    output logic              rd_start_rq,
    output logic [AWIDTH-1:0] rd_in_addr,
    input  logic              rdat_m_valid,
    input  logic              finish_mrd,
    output logic              mrd_gnt_dc,
    output logic              mrd_busy
);

    typedef enum logic [2:0] {
        IDLE,
        IC_ISS,
        IC_WAIT,
        DC_ISS,
        DC_WAIT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              ic_pend;
    logic              dc_pend;
    logic              drop;
    logic [AWIDTH-1:0] ic_addr;
    logic [AWIDTH-1:0] dc_addr;
    logic [AWIDTH-1:0] addr_q;
    logic              ic_req;
    logic              pick_dc;
    logic              ic_enter;
    logic              dc_enter;
    logic              ic_gnt;

    // A pipeline flush in the same cycle must not let a stale IC request win
    assign ic_req = ic_pend & ~rst_pipe;

`ifdef MRD_RR_ARB_EN
    logic last_dc;

    assign pick_dc = dc_pend & (~ic_req | ~last_dc);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dc <= 1'b0;
        end else if (ic_enter) begin
            last_dc <= 1'b0;
        end else if (dc_enter) begin
            last_dc <= 1'b1;
        end
    end
`else
    assign pick_dc = dc_pend;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (pick_dc) begin
                    state_nx = DC_ISS;
                end else if (ic_req) begin
                    state_nx = IC_ISS;
                end
            end
            IC_ISS:  state_nx = IC_WAIT;
            IC_WAIT: if (finish_mrd) state_nx = IDLE;
            DC_ISS:  state_nx = DC_WAIT;
            DC_WAIT: if (finish_mrd) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ic_enter = (state == IDLE) && (state_nx == IC_ISS);
    assign dc_enter = (state == IDLE) && (state_nx == DC_ISS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ic_pend <= 1'b0;
            dc_pend <= 1'b0;
            drop    <= 1'b0;
            ic_addr <= '0;
            dc_addr <= '0;
            addr_q  <= '0;
        end else begin
            state <= state_nx;
            if (rst_pipe) begin
                ic_pend <= 1'b0;
            end else if (icr_start_rq) begin
                ic_pend <= 1'b1;
                ic_addr <= ic_rin_addr;
            end else if (ic_enter) begin
                ic_pend <= 1'b0;
            end
            if (dcr_start_rq) begin
                dc_pend <= 1'b1;
                dc_addr <= dc_rin_addr;
            end else if (dc_enter) begin
                dc_pend <= 1'b0;
            end
            if (ic_enter) begin
                addr_q <= ic_addr;
            end else if (dc_enter) begin
                addr_q <= dc_addr;
            end
            if (state_nx == IDLE) begin
                drop <= 1'b0;
            end else if (rst_pipe && ic_gnt) begin
                drop <= 1'b1;
            end
        end
    end

    assign ic_gnt     = (state == IC_ISS) || (state == IC_WAIT);
    assign mrd_gnt_dc = (state == DC_ISS) || (state == DC_WAIT);
    assign mrd_busy   = (state != IDLE);
    assign rd_start_rq = (state == IC_ISS) || (state == DC_ISS);
    assign rd_in_addr = addr_q;

    assign dc_rdat_m_valid = rdat_m_valid & mrd_gnt_dc;
    assign dc_finish_mrd   = finish_mrd & mrd_gnt_dc;
    assign ic_rdat_m_valid = rdat_m_valid & ic_gnt & ~drop & ~rst_pipe;
    assign ic_finish_mrd   = finish_mrd & ic_gnt & ~drop & ~rst_pipe;

endmodule

// File: tb/tb_mrd_arbiter.sv
// Directed and randomized bench for mrd_arbiter against a transaction-level model.
module tb_mrd_arbiter;

    logic        clk;
    logic        rst;
    logic        rst_pipe;
    logic        icr_start_rq;
    logic [31:0] ic_rin_addr;
    logic        ic_rdat_m_valid;
    logic        ic_finish_mrd;
    logic        dcr_start_rq;
    logic [31:0] dc_rin_addr;
    logic        dc_rdat_m_valid;
    logic        dc_finish_mrd;
    logic        rd_start_rq;
    logic [31:0] rd_in_addr;
    logic        rdat_m_valid;
    logic        finish_mrd;
    logic        mrd_gnt_dc;
    logic        mrd_busy;

    int checks = 0;
    int errors = 0;

    mrd_arbiter #(.AWIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .rst_pipe(rst_pipe),
        .icr_start_rq(icr_start_rq),
        .ic_rin_addr(ic_rin_addr),
        .ic_rdat_m_valid(ic_rdat_m_valid),
        .ic_finish_mrd(ic_finish_mrd),
        .dcr_start_rq(dcr_start_rq),
        .dc_rin_addr(dc_rin_addr),
        .dc_rdat_m_valid(dc_rdat_m_valid),
        .dc_finish_mrd(dc_finish_mrd),
        .rd_start_rq(rd_start_rq),
        .rd_in_addr(rd_in_addr),
        .rdat_m_valid(rdat_m_valid),
        .finish_mrd(finish_mrd),
        .mrd_gnt_dc(mrd_gnt_dc),
        .mrd_busy(mrd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: owner 0 = none, 1 = IC, 2 = DC; age counts cycles since the grant
    int          m_own;
    int          m_age;
    bit          m_icp;
    bit          m_dcp;
    bit          m_drop;
    bit          m_last_dc;
    logic [31:0] m_ica;
    logic [31:0] m_dca;
    logic [31:0] m_addr;

    logic        s_busy;
    logic        s_start;
    logic        s_gnt;
    logic        s_icv;
    logic        s_icf;
    logic        s_dcv;
    logic        s_dcf;
    logic [31:0] s_addr;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int  nown;
        bit  ic_req;
        bit  win_dc;
        bit  grant;
        if (rst) begin
            m_own = 0; m_age = 0; m_icp = 0; m_dcp = 0; m_drop = 0;
            m_last_dc = 0; m_ica = 0; m_dca = 0; m_addr = 0;
            return;
        end
        ic_req = m_icp && !rst_pipe;
        nown   = m_own;
        grant  = 0;
        win_dc = 0;
        if (m_own == 0) begin
            if (m_dcp && ic_req) begin
`ifdef MRD_RR_ARB_EN
                win_dc = !m_last_dc;
`else
                win_dc = 1;
`endif
                grant = 1;
            end else if (m_dcp || ic_req) begin
                win_dc = m_dcp;
                grant  = 1;
            end
            if (grant) nown = win_dc ? 2 : 1;
        end else if (m_age >= 1 && finish_mrd) begin
            nown = 0;
        end
        if (nown == 0) m_drop = 0;
        else if (m_own == 1 && rst_pipe) m_drop = 1;
        if (grant) begin
            m_addr    = win_dc ? m_dca : m_ica;
            m_last_dc = win_dc;
            m_age     = 0;
        end else if (m_own != 0) begin
            m_age++;
        end
        if (rst_pipe) m_icp = 0;
        else if (icr_start_rq) begin m_icp = 1; m_ica = ic_rin_addr; end
        else if (grant && !win_dc) m_icp = 0;
        if (dcr_start_rq) begin m_dcp = 1; m_dca = dc_rin_addr; end
        else if (grant && win_dc) m_dcp = 0;
        m_own = nown;
    endtask

    task automatic cyc();
        bit e_ic;
        @(negedge clk);
        s_busy = mrd_busy; s_start = rd_start_rq; s_gnt = mrd_gnt_dc;
        s_icv = ic_rdat_m_valid; s_icf = ic_finish_mrd;
        s_dcv = dc_rdat_m_valid; s_dcf = dc_finish_mrd;
        s_addr = rd_in_addr;
        e_ic = (m_own == 1) && !m_drop && !rst_pipe;
        chk1("busy", s_busy, m_own != 0);
        chk1("start", s_start, m_own != 0 && m_age == 0);
        chk1("gnt_dc", s_gnt, m_own == 2);
        chkw("addr", s_addr, m_addr);
        chk1("ic_valid", s_icv, e_ic && rdat_m_valid);
        chk1("ic_finish", s_icf, e_ic && finish_mrd);
        chk1("dc_valid", s_dcv, m_own == 2 && rdat_m_valid);
        chk1("dc_finish", s_dcf, m_own == 2 && finish_mrd);
        @(posedge clk);
        model_step();
        #1;
        icr_start_rq = 0; dcr_start_rq = 0; rst_pipe = 0; rst = 0;
        rdat_m_valid = 0; finish_mrd = 0;
    endtask

    task automatic serve(input bit repulse, output logic gdc,
                         output logic [31:0] a);
        int n = 0;
        s_start = 0;
        while (n < 12 && s_start !== 1'b1) begin
            cyc();
            n++;
        end
        chk1("grant_timeout", s_start, 1'b1);
        gdc = s_gnt;
        a   = s_addr;
        if (repulse) begin
            icr_start_rq = 1; ic_rin_addr = $urandom;
            dcr_start_rq = 1; dc_rin_addr = $urandom;
        end
        rdat_m_valid = 1;
        cyc();
        rdat_m_valid = 1;
        finish_mrd = 1;
        cyc();
    endtask

    logic        g;
    logic [31:0] ga;

    initial begin
        rst = 1; rst_pipe = 0; icr_start_rq = 0; dcr_start_rq = 0;
        ic_rin_addr = 0; dc_rin_addr = 0; rdat_m_valid = 0; finish_mrd = 0;
        repeat (2) @(posedge clk);
        model_step();
        #1;
        rst = 0;
        cyc();
        chk1("rst_busy", s_busy, 1'b0);
        chk1("rst_start", s_start, 1'b0);
        chkw("rst_addr", s_addr, 32'h0);

        // IC alone
        icr_start_rq = 1; ic_rin_addr = 32'h0000_1230;
        cyc();
        cyc();
        cyc();
        chk1("ic_start_c2", s_start, 1'b1);
        chkw("ic_addr_c2", s_addr, 32'h0000_1230);
        chk1("ic_gnt_c2", s_gnt, 1'b0);
        rdat_m_valid = 1;
        cyc();
        chk1("ic_data", s_icv, 1'b1);
        chk1("ic_no_dc", s_dcv, 1'b0);
        finish_mrd = 1;
        cyc();
        chk1("ic_fin", s_icf, 1'b1);
        cyc();
        chk1("ic_idle", s_busy, 1'b0);

        // Collision
        icr_start_rq = 1; ic_rin_addr = 32'h100;
        dcr_start_rq = 1; dc_rin_addr = 32'h2000;
        cyc();
        cyc();
        cyc();
        chk1("col_start1", s_start, 1'b1);
        chkw("col_addr1", s_addr, 32'h2000);
        chk1("col_gnt1", s_gnt, 1'b1);
        finish_mrd = 1;
        cyc();
        cyc();
        chk1("col_gap", s_start, 1'b0);
        cyc();
        chk1("col_start2", s_start, 1'b1);
        chkw("col_addr2", s_addr, 32'h100);
        finish_mrd = 1;
        cyc();

        // Repeated ties
        icr_start_rq = 1; dcr_start_rq = 1;
        ic_rin_addr = 32'h500; dc_rin_addr = 32'h600;
        cyc();
        for (int k = 0; k < 6; k++) begin
            serve(k < 5, g, ga);
`ifdef MRD_RR_ARB_EN
            chk1("rr_order", g, (k % 2) == 0);
`else
            chk1("fixed_order", g, 1'b1);
`endif
        end
        serve(0, g, ga);
        repeat (2) cyc();

        // rst_pipe during IC_WAIT
        icr_start_rq = 1; ic_rin_addr = 32'h300;
        cyc();
        cyc();
        cyc();
        rst_pipe = 1; dcr_start_rq = 1; dc_rin_addr = 32'h4000;
        cyc();
        rdat_m_valid = 1;
        cyc();
        chk1("drop_valid", s_icv, 1'b0);
        chk1("drop_busy", s_busy, 1'b1);
        rdat_m_valid = 1; finish_mrd = 1;
        cyc();
        chk1("drop_fin", s_icf, 1'b0);
        serve(0, g, ga);
        chk1("drop_dc_gnt", g, 1'b1);
        chkw("drop_dc_addr", ga, 32'h4000);
        cyc();

        // Overwrite while DC in flight
        dcr_start_rq = 1; dc_rin_addr = 32'h5000;
        cyc();
        cyc();
        cyc();
        icr_start_rq = 1; ic_rin_addr = 32'h40;
        cyc();
        icr_start_rq = 1; ic_rin_addr = 32'h80;
        cyc();
        finish_mrd = 1;
        cyc();
        serve(0, g, ga);
        chk1("ovw_gnt", g, 1'b0);
        chkw("ovw_addr", ga, 32'h80);
        cyc();
        cyc();
        chk1("ovw_single", s_start, 1'b0);

        // Reset in DC_WAIT
        dcr_start_rq = 1; dc_rin_addr = 32'h6000;
        cyc();
        cyc();
        cyc();
        cyc();
        rst = 1;
        cyc();
        rdat_m_valid = 1; finish_mrd = 1;
        cyc();
        chk1("rst_mid_busy", s_busy, 1'b0);
        chkw("rst_mid_addr", s_addr, 32'h0);
        chk1("rst_mid_dcf", s_dcf, 1'b0);
        chk1("rst_mid_dcv", s_dcv, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            icr_start_rq = ($urandom_range(5) == 0);
            dcr_start_rq = ($urandom_range(5) == 0);
            ic_rin_addr  = $urandom;
            dc_rin_addr  = $urandom;
            rst_pipe     = ($urandom_range(29) == 0);
            rst          = ($urandom_range(199) == 0);
            if (m_own != 0 && m_age >= 1) begin
                rdat_m_valid = $urandom_range(1);
                finish_mrd   = ($urandom_range(3) == 0);
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrd_arbiter.md
Name: mrd_arbiter

Overview:
- Shares the single tiny-AXI read master between the I-cache refill requester (ilu stage) and the D-cache refill requester.
- Latches one-cycle start pulses and arbitrates between them.
- Issues one bus read at a time, then steers the returned valid and finish strobes back to the granted requester.
- Sits between the ilu/dc miss state machines and the bus read master.

Parameters:
- AWIDTH, 32, byte-address width of request and bus addresses.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rst_pipe  input  1  pipeline reset; cancels IC traffic
- icr_start_rq  input  1  IC refill request pulse
- ic_rin_addr  input  AWIDTH  IC refill address, valid with pulse
- ic_rdat_m_valid  output  1  bus read data valid, routed to IC
- ic_finish_mrd  output  1  bus read finished, routed to IC
- dcr_start_rq  input  1  DC refill request pulse
- dc_rin_addr  input  AWIDTH  DC refill address, valid with pulse
- dc_rdat_m_valid  output  1  bus read data valid, routed to DC
- dc_finish_mrd  output  1  bus read finished, routed to DC
- rd_start_rq  output  1  bus read start pulse
- rd_in_addr  output  AWIDTH  bus read address
- rdat_m_valid  input  1  bus read data valid
- finish_mrd  input  1  bus read transaction complete
- mrd_gnt_dc  output  1  1 = bus data belongs to DC (data mux select)
- mrd_busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- Reset:
  - state = IDLE; both pending bits, the drop flag and all outputs = 0.
  - Address registers = 0.
  - Round-robin pointer (if enabled) = "IC last".
- Pending latches:
  - icr_start_rq sets ic_pend and captures ic_rin_addr; dcr_start_rq does the same for DC.
  - A pulse while its own pend is already set overwrites the address; still one request.
  - A pend bit clears on the cycle its ISS state is entered.
- State machine:
  - States: IDLE, IC_ISS, IC_WAIT, DC_ISS, DC_WAIT.
  - IDLE: if dc_pend -> DC_ISS; else if ic_pend -> IC_ISS; else stay.
  - x_ISS: always -> x_WAIT next cycle.
  - x_WAIT: finish_mrd = 1 -> IDLE; else stay.
  - finish_mrd in x_ISS is ignored; the bus never finishes in the start cycle.
- Bus outputs:
  - rd_start_rq = 1 exactly for the single cycle state is IC_ISS or DC_ISS.
  - rd_in_addr is loaded with the granted latched address on entry to ISS and held until the next grant.
- Latency:
  - Start pulse at cycle 0 -> pend = 1 at cycle 1 -> rd_start_rq = 1 at cycle 2 when the bus is idle.
  - finish_mrd at cycle N -> IDLE at N+1 -> the next rd_start_rq is no earlier than N+2.
- Routing:
  - mrd_gnt_dc = 1 in DC_ISS and DC_WAIT, 0 otherwise.
  - dc_rdat_m_valid = rdat_m_valid & mrd_gnt_dc; dc_finish_mrd likewise.
  - IC strobes are gated by IC grant and ~drop (combinational, same cycle).
  - Outside WAIT/ISS, all routed strobes are 0.
- Simultaneous requests:
  - IC and DC pulses in the same cycle -> DC issued first; IC stays pending and issues after DC finish.
  - A new request from the requester currently in flight is latched and served afterwards.
- rst_pipe:
  - Clears ic_pend.
  - If the IC transaction is in ISS/WAIT, sets drop. The bus transaction runs to finish_mrd, but ic_rdat_m_valid and ic_finish_mrd stay 0. drop clears when returning to IDLE.
  - An icr_start_rq in the same cycle as rst_pipe is discarded.
  - DC state is unaffected.
- rst mid-transaction: returns to IDLE immediately and clears everything; the bus side is reset in the same domain.

Optional Feature:
- Macro: MRD_RR_ARB_EN.
- Defined:
  - Round-robin arbitration. When both pend bits are set in IDLE, grant the requester that was not granted last.
  - The pointer updates on each ISS entry; reset value "IC last", so DC wins the first tie.
  - A lone pending request is granted regardless of the pointer.
- Undefined: fixed priority, DC over IC; no pointer register.

Test Plan:
- IC alone: icr_start_rq pulse at cycle 0 with addr 0x0000_1230 -> rd_start_rq = 1 at cycle 2 with rd_in_addr = 0x0000_1230, mrd_gnt_dc = 0. rdat_m_valid pulses appear on ic_rdat_m_valid, none on dc_rdat_m_valid. finish_mrd -> ic_finish_mrd = 1 and IDLE next cycle.
- Collision: IC 0x100 and DC 0x2000 pulses in the same cycle -> first rd_start_rq carries 0x2000 with mrd_gnt_dc = 1. After finish_mrd, the second rd_start_rq carries 0x100 two cycles later.
- Round-robin (MRD_RR_ARB_EN): three back-to-back colliding IC/DC pairs -> grant order DC, IC, DC, IC, DC, IC. Without the macro: DC, DC, DC first each round.
- rst_pipe during IC_WAIT -> bus still completes on finish_mrd. ic_rdat_m_valid and ic_finish_mrd stay 0 throughout. A queued DC request then issues normally.
- Overwrite: two icr_start_rq pulses (0x40, then 0x80) while DC is in flight -> exactly one IC bus read, address 0x80.
- Reset: rst asserted in DC_WAIT -> next cycle mrd_busy = 0, rd_in_addr = 0, all strobes 0. A later finish_mrd produces no routed strobe.
